// File: rtl/rpsc_ps_sequencer_pkg.sv
// ============================================================================
// Module : rpsc_pkg
// Brief  : State encoding and fault codes for the RPSC supply sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rpsc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_G1_RAMP  = 3'd1,
        ST_AN_WAIT  = 3'd2,
        ST_AN_RAMP  = 3'd3,
        ST_RUN      = 3'd4,
        ST_SHUTDOWN = 3'd5,
        ST_FAULT    = 3'd6
    } ps_state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_G1_ALARM = 3'd1;
    localparam logic [2:0] FC_G1_TMO   = 3'd2;
    localparam logic [2:0] FC_G1_LOSS  = 3'd3;
    localparam logic [2:0] FC_AN_TMO   = 3'd4;
    localparam logic [2:0] FC_AN_LOSS  = 3'd5;
    localparam logic [2:0] FC_AN_ALARM = 3'd6;

    // G1 supply is commanded on in every sequencing state, including SHUTDOWN.
    function automatic logic is_active(input ps_state_t s);
        return (s == ST_G1_RAMP) || (s == ST_AN_WAIT) || (s == ST_AN_RAMP) ||
               (s == ST_RUN) || (s == ST_SHUTDOWN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rpsc_ps_sequencer_if.sv
// ============================================================================
// Module : rpsc_ps_sequencer_if
// Brief  : Request, interlock-status and supply-control signals of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rpsc_ps_sequencer_if;

    logic       start_req;
    logic       stop_req;
    logic       fault_clr;
    logic       g1_no_alarm;
    logic       g1_ok_n;
    logic       an_ready_n;
    logic       an_no_alarm;
    logic       an_ok_n;
    logic       g1_ps_act;
    logic       an_ps_act;
    logic       busy;
    logic       fault;
    logic [2:0] fault_code;
    logic [2:0] state_o;

    modport master (
        output start_req, stop_req, fault_clr,
        output g1_no_alarm, g1_ok_n, an_ready_n, an_no_alarm, an_ok_n,
        input  g1_ps_act, an_ps_act, busy, fault, fault_code, state_o
    );

    modport slave (
        input  start_req, stop_req, fault_clr,
        input  g1_no_alarm, g1_ok_n, an_ready_n, an_no_alarm, an_ok_n,
        output g1_ps_act, an_ps_act, busy, fault, fault_code, state_o
    );

endinterface

`default_nettype wire

// File: rtl/rpsc_ps_sequencer_stage_cnt.sv
// ============================================================================
// Module : rpsc_stage_cnt
// Brief  : Clearable saturating up-counter with equality compare to a limit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rpsc_stage_cnt #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    input  wire logic [CNT_W-1:0] i_limit,
    output logic                  o_eq
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_eq = (r_cnt == i_limit);

endmodule

`default_nettype wire

// File: rtl/rpsc_ps_sequencer.sv
// ============================================================================
// Module : rpsc_ps_sequencer
// Brief  : G1-then-anode turn-on / anode-then-G1 turn-off supply sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rpsc_ps_sequencer
    import rpsc_pkg::*;
#(
    parameter int               CNT_W      = 8,
    parameter logic [CNT_W-1:0] G1_TMO     = CNT_W'(12),
    parameter logic [CNT_W-1:0] AN_TMO     = CNT_W'(20),
    parameter logic [CNT_W-1:0] AN_OFF_DLY = CNT_W'(4)
) (
    input wire logic             clk,
    input wire logic             reset,
    rpsc_ps_sequencer_if.slave   bus
);

    ps_state_t        r_state;
    ps_state_t        w_next;
    logic [2:0]       w_code;
    logic [2:0]       r_fault_code;
    logic             r_g1_act;
    logic             r_an_act;
    logic             r_busy;
    logic             r_fault;
    logic             w_cnt_eq;
    logic             w_cnt_inc;
    logic             w_cnt_clr;
    logic [CNT_W-1:0] w_limit;

    // Shutdown compares against DLY-1 so G1 drops exactly DLY cycles after the anode.
    always_comb begin
        w_limit = G1_TMO;
        case (r_state)
            ST_AN_RAMP:  w_limit = AN_TMO;
            ST_SHUTDOWN: w_limit = AN_OFF_DLY - 1'b1;
            default:     w_limit = G1_TMO;
        endcase
    end

    assign w_cnt_inc = (r_state == ST_G1_RAMP) || (r_state == ST_AN_RAMP) ||
                       (r_state == ST_SHUTDOWN);
    assign w_cnt_clr = (w_next != r_state);

    rpsc_stage_cnt #(
        .CNT_W (CNT_W)
    ) u_stage_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .i_limit (w_limit),
        .o_eq    (w_cnt_eq)
    );

    // Priority: alarm > OK-loss/timeout > stop > advance.
    always_comb begin
        w_next = r_state;
        w_code = r_fault_code;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_req && bus.g1_no_alarm) w_next = ST_G1_RAMP;
            end
            ST_G1_RAMP: begin
                if (!bus.g1_no_alarm) begin
                    w_next = ST_FAULT; w_code = FC_G1_ALARM;
                end else if (w_cnt_eq) begin
                    w_next = ST_FAULT; w_code = FC_G1_TMO;
                end else if (bus.stop_req) begin
                    w_next = ST_SHUTDOWN;
                end else if (!bus.g1_ok_n) begin
                    w_next = ST_AN_WAIT;
                end
            end
            ST_AN_WAIT: begin
                if (!bus.g1_no_alarm) begin
                    w_next = ST_FAULT; w_code = FC_G1_ALARM;
                end else if (bus.stop_req) begin
                    w_next = ST_SHUTDOWN;
                end else if (!bus.an_ready_n && bus.an_no_alarm) begin
                    w_next = ST_AN_RAMP;
                end
            end
            ST_AN_RAMP: begin
                if (!bus.g1_no_alarm) begin
                    w_next = ST_FAULT; w_code = FC_G1_ALARM;
                end else if (!bus.an_no_alarm) begin
                    w_next = ST_FAULT; w_code = FC_AN_ALARM;
                end else if (w_cnt_eq) begin
                    w_next = ST_FAULT; w_code = FC_AN_TMO;
                end else if (bus.stop_req) begin
                    w_next = ST_SHUTDOWN;
                end else if (!bus.an_ok_n) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.g1_no_alarm) begin
                    w_next = ST_FAULT; w_code = FC_G1_ALARM;
                end else if (!bus.an_no_alarm) begin
                    w_next = ST_FAULT; w_code = FC_AN_ALARM;
                end else if (bus.g1_ok_n) begin
                    w_next = ST_FAULT; w_code = FC_G1_LOSS;
                end else if (bus.an_ok_n) begin
                    w_next = ST_FAULT; w_code = FC_AN_LOSS;
                end else if (bus.stop_req) begin
                    w_next = ST_SHUTDOWN;
                end
            end
            ST_SHUTDOWN: begin
                if (!bus.g1_no_alarm) begin
                    w_next = ST_FAULT; w_code = FC_G1_ALARM;
                end else if (!bus.an_no_alarm) begin
                    w_next = ST_FAULT; w_code = FC_AN_ALARM;
                end else if (w_cnt_eq) begin
                    w_next = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr && bus.g1_no_alarm && bus.an_no_alarm) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_g1_act     <= 1'b0;
            r_an_act     <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            r_state      <= w_next;
            r_g1_act     <= is_active(w_next);
            r_an_act     <= (w_next == ST_AN_RAMP) || (w_next == ST_RUN);
            r_busy       <= is_active(w_next);
            r_fault      <= (w_next == ST_FAULT);
            r_fault_code <= (w_next == ST_FAULT) ? w_code : FC_NONE;
        end
    end

    assign bus.g1_ps_act  = r_g1_act;
    assign bus.an_ps_act  = r_an_act;
    assign bus.busy       = r_busy;
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_fault_code;
    assign bus.state_o    = r_state;

endmodule

`default_nettype wire
